// File: rtl/demultiplexer_4_outputs_pkg.sv
// demultiplexer_4_outputs_pkg: shared widths and channel-to-select mapping
package demultiplexer_4_outputs_pkg;
  localparam int WIDTH = 64;
  localparam int NUM_OUT = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 2;
  function automatic logic [SEL_W-1:0] ch_to_sel(input int k);
    return SEL_W'(k);
  endfunction
endpackage

// File: rtl/demultiplexer_4_outputs_fifo2.sv
// demux_fifo2: 2-entry per-channel FIFO, caller guarantees no push when full or pop when empty
module demux_fifo2
  import demultiplexer_4_outputs_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count
);
  logic [W-1:0] mem [2];
  logic wr_ptr, rd_ptr;
  assign head_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= (push && !pop) ? count + 2'd1 : (pop && !push) ? count - 2'd1 : count;
    end
  end
endmodule

// File: rtl/demultiplexer_4_outputs.sv
// demultiplexer_4_outputs: registered 1-to-4 demux with a 2-entry FIFO per output channel
module demultiplexer_4_outputs
  import demultiplexer_4_outputs_pkg::*;
#(
  parameter int WIDTH = demultiplexer_4_outputs_pkg::WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT*CNT_W-1:0] out_count
);
  logic [CNT_W-1:0] cnt [NUM_OUT];
  logic [WIDTH-1:0] head [NUM_OUT];
  // Ready depends only on registered occupancy, never on out_ready
  assign in_ready = cnt[in_sel] != CNT_W'(DEPTH);
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
    demux_fifo2 #(.W(WIDTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(in_valid && in_ready && in_sel == ch_to_sel(k)),
      .push_data(in_data),
      .pop(out_valid[k] && out_ready[k]),
      .head_data(head[k]),
      .count(cnt[k])
    );
    assign out_valid[k] = cnt[k] != '0;
    assign out_data[k*WIDTH +: WIDTH] = head[k];
    assign out_count[k*CNT_W +: CNT_W] = cnt[k];
  end
endmodule

// File: tb/tb_demultiplexer_4_outputs.sv
// tb_demultiplexer_4_outputs: queue scoreboard bench for the 4-way demux
module tb_demultiplexer_4_outputs;
  logic clk = 0, rst = 1, in_valid = 0, in_ready;
  logic [63:0] in_data = '0;
  logic [1:0] in_sel = '0;
  logic [3:0] out_valid, out_ready = '0;
  logic [255:0] out_data;
  logic [7:0] out_count;
  logic [63:0] q [4][$];
  int errs = 0, checks = 0;

  demultiplexer_4_outputs dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare state against the model, then advance model and DUT by one edge
  task automatic step();
    logic [3:0] pop;
    logic mr;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("count%0d", k), 256'(out_count[2*k +: 2]), 256'(q[k].size()));
      chk($sformatf("valid%0d", k), 256'(out_valid[k]), 256'(q[k].size() != 0));
      if (q[k].size() != 0) chk($sformatf("data%0d", k), 256'(out_data[64*k +: 64]), 256'(q[k][0]));
    end
    mr = q[in_sel].size() != 2;
    chk("in_ready", 256'(in_ready), 256'(mr));
    for (int k = 0; k < 4; k++) pop[k] = out_ready[k] && q[k].size() != 0;
    if (rst) begin
      for (int k = 0; k < 4; k++) q[k].delete();
    end else begin
      for (int k = 0; k < 4; k++) if (pop[k]) void'(q[k].pop_front());
      if (in_valid && mr) q[in_sel].push_back(in_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [63:0] d);
    in_valid = v;
    in_sel = s;
    in_data = d;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_data", out_data, '0);
    for (int s = 0; s < 4; s++) begin
      drive(0, 2'(s), '1);
      step();
    end
    out_ready = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      drive(1, 2'(s), 64'(1) << s);
      step();
    end
    drive(0, 0, 0);
    repeat (2) step();
    out_ready = 4'b1011;
    drive(1, 2, 64'hA);
    step();
    drive(1, 2, 64'hB);
    step();
    drive(1, 2, 64'hC);
    repeat (2) step();
    out_ready = 4'b1111;
    repeat (2) step();
    drive(0, 0, 0);
    repeat (3) step();
    out_ready = 4'b1101;
    drive(1, 1, 64'h11);
    step();
    drive(1, 1, 64'h12);
    step();
    drive(1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    drive(0, 0, 0);
    repeat (2) step();
    out_ready = 4'b1111;
    repeat (3) step();
    out_ready = 4'b0000;
    drive(1, 3, 64'h33);
    step();
    out_ready = 4'b1000;
    drive(1, 3, 64'h44);
    step();
    out_ready = 4'b0000;
    drive(0, 0, 0);
    step();
    drive(1, 3, 64'h51);
    step();
    drive(1, 0, 64'h52);
    step();
    drive(1, 3, 64'h53);
    rst = 1;
    step();
    rst = 0;
    drive(0, 3, 0);
    step();
    chk("rst_count", 256'(out_count), 256'(0));
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_data2", out_data, '0);
    out_ready = 4'b1111;
    repeat (2) step();
    for (int i = 0; i < 300; i++) begin
      out_ready = 4'($urandom);
      drive(1'($urandom), 2'($urandom), {$urandom, $urandom});
      step();
    end
    drive(0, 0, 0);
    out_ready = 4'b1111;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
